mef_seq: RTL and testbench
==========================

# mef_seq

Parametrised successor of the two-bit process-control state machine. It sequences a single work cycle:
- arm on a clear guard/sensor pair;
- run the motor until a configurable number of `ev` pulses has been counted;
- wait for `rd` release under a watchdog timeout;
- signal done and restart on `back`.

Over its predecessor it adds an explicit error state with cause reporting, bounded retries, rising-edge event counting and a completed-cycle counter. It sits between the panel/sensor inputs and the actuator/lamp outputs of the controller.

## Interface
- `EV_COUNT`, default 4: `ev` rising edges required to finish RUN (≥1).
- `EV_W`, default 4: width of the event counter; must hold `EV_COUNT`.
- `TIMEOUT`, default 16: maximum cycles spent in WAIT_RD with `rd` high (≥1).
- `TO_W`, default 8: width of the watchdog timer; must hold `TIMEOUT-1`.
- `MAX_RETRY`, default 2: ERROR→RUN recoveries allowed before lockout.
- `DONE_W`, default 8: width of `done_cnt`.
- `clk`, in, 1: single clock, all logic on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `g`, `s`, in, 1 each: guard and sensor; both low arms the cycle.
- `ev`, in, 1: event input, counted on rising edges.
- `rd`, in, 1: ready/hold; low releases WAIT_RD.
- `back`, in, 1: restart / acknowledge.
- `M`, out, 1: motor enable.
- `LEV`, out, 1: "awaiting events" lamp.
- `Lerro`, out, 1: error lamp.
- `D`, out, 1: done indicator.
- `state_o`, out, 3: current state code.
- `err_code`, out, 2: error cause. 00 = none, 01 = guard opened, 10 = rd timeout.
- `done_cnt`, out, `DONE_W`: completed cycles; wraps modulo 2^`DONE_W`.

## Operation
- Reset values:
  - state IDLE;
  - `ev_cnt`, `timer`, `retry`, `done_cnt`, `err_code` = 0;
  - `ev_q` = 0;
  - `M`, `LEV`, `Lerro`, `D` = 0.
- State codes: IDLE=000, RUN=001, WAIT_RD=010, DONE=011, ERROR=100. Unused codes go to IDLE on the next edge.
- Outputs are Moore and decoded from the state register only:
  - `M` = RUN | WAIT_RD;
  - `LEV` = RUN;
  - `Lerro` = ERROR;
  - `D` = DONE.
- Edge detect: `ev_q` <= `ev` every cycle, in every state. A rise is `ev & ~ev_q`. A level that is already high when RUN is entered is not counted.
- IDLE:
  - `~g & ~s` → RUN; clear `ev_cnt`.
  - Otherwise stay.
- RUN, with priority g > ev:
  - `g`=1 → ERROR, `err_code`=01.
  - Otherwise, on a rise, `ev_cnt`+1. When the incremented value equals `EV_COUNT` → WAIT_RD and clear `timer`.
- WAIT_RD:
  - `rd`=0 → DONE; `done_cnt`+1.
  - `rd`=1 and `timer`==`TIMEOUT-1` → ERROR, `err_code`=10.
  - `rd`=1 otherwise: `timer`+1.
  - If `rd`=0 and timeout fall on the same cycle, `rd`=0 wins.
- DONE:
  - `back`=1 → RUN; clear `ev_cnt`.
  - Otherwise stay.
  - `retry` is not cleared here. Only reset clears it.
- ERROR:
  - `back & ~g` and `retry` < `MAX_RETRY` → RUN; `retry`+1; clear `ev_cnt` and `err_code`.
  - `retry` == `MAX_RETRY` → lockout: stay in ERROR regardless of inputs until `reset`.
- Counters saturate nowhere except `done_cnt`, which wraps.

## Timing
- Every transition takes effect on the `clk` edge where its condition is sampled. Outputs change on that same edge, with no extra latency.
- Minimum RUN duration: `EV_COUNT` rises. With `ev` toggling every cycle, that is 2·`EV_COUNT`-1 cycles in RUN, measured from the first rise.
- WAIT_RD with `rd` held high lasts exactly `TIMEOUT` cycles, then ERROR.
- `reset` takes priority over all transitions and returns to IDLE at the next edge. This holds mid-run, during lockout, and in any other state.

## Test plan
- Nominal cycle (EV_COUNT=4):
  - stimulus: `g`=`s`=0, then 4 `ev` pulses, then `rd`=0 after 3 cycles;
  - response: sequence IDLE→RUN→WAIT_RD→DONE, `M`=1 throughout RUN/WAIT_RD, `LEV`=1 only in RUN, `D`=1 in DONE, `done_cnt`=1.
  - Then `back`=1 → RUN with `ev_cnt`=0.
- Edge counting:
  - stimulus: `ev` already high on RUN entry and held for 10 cycles;
  - response: `ev_cnt` stays 0; 4 later distinct pulses reach WAIT_RD.
- Timeout (TIMEOUT=16):
  - stimulus: `rd` held 1;
  - response: ERROR on the 16th cycle after WAIT_RD entry, `err_code`=10, `Lerro`=1, `M`=0.
  - Variant: `rd` drops on that same cycle → DONE.
- Guard open in RUN:
  - stimulus: `g`=1 together with an `ev` rise;
  - response: ERROR, `err_code`=01, event not counted.
- Retry/lockout (MAX_RETRY=2):
  - stimulus: `back` with `g`=0 from ERROR twice;
  - response: RUN each time, `err_code` cleared.
  - Stimulus: third error, then `back`;
  - response: stays in ERROR.
  - Stimulus: then `reset`;
  - response: IDLE, `retry`=0, all outputs 0.
- Reset mid-operation and wrap:
  - stimulus: `reset` asserted in WAIT_RD;
  - response: IDLE on the next edge.
  - Stimulus: 256 completed cycles with DONE_W=8;
  - response: `done_cnt` wraps to 0.

Source files
------------

// File: rtl/mef_seq.sv
// Work-cycle sequencer: arm on clear guard/sensor, run motor for EV_COUNT event rises,
// wait for rd release under a watchdog, then done; error state with bounded retries.
module mef_seq #(
  parameter int unsigned EV_COUNT  = 4,
  parameter int unsigned EV_W      = 4,
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned TO_W      = 8,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned DONE_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              g,
  input  logic              s,
  input  logic              ev,
  input  logic              rd,
  input  logic              back,
  output logic              M,
  output logic              LEV,
  output logic              Lerro,
  output logic              D,
  output logic [2:0]        state_o,
  output logic [1:0]        err_code,
  output logic [DONE_W-1:0] done_cnt
);

  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [EV_W-1:0] EvTarget = EV_W'(EV_COUNT);
  localparam logic [TO_W-1:0] ToLast   = TO_W'(TIMEOUT - 1);
  localparam logic [RW-1:0]   RetryMax = RW'(MAX_RETRY);

  localparam logic [2:0] StIdle   = 3'b000;
  localparam logic [2:0] StRun    = 3'b001;
  localparam logic [2:0] StWaitRd = 3'b010;
  localparam logic [2:0] StDone   = 3'b011;
  localparam logic [2:0] StError  = 3'b100;

  logic [2:0]        state_q, state_d;
  logic              ev_q;
  logic [EV_W-1:0]   ev_cnt_q, ev_cnt_d;
  logic [TO_W-1:0]   timer_q, timer_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [DONE_W-1:0] done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic              ev_rise;
  logic [EV_W-1:0]   ev_inc;

  assign ev_rise = ev & ~ev_q;
  assign ev_inc  = ev_cnt_q + EV_W'(1);

  always_comb begin
    state_d  = state_q;
    ev_cnt_d = ev_cnt_q;
    timer_d  = timer_q;
    retry_d  = retry_q;
    done_d   = done_q;
    err_d    = err_q;
    case (state_q)
      StIdle: begin
        if (!g && !s) begin
          state_d  = StRun;
          ev_cnt_d = '0;
        end
      end
      StRun: begin
        // Guard beats a simultaneous event rise; that rise is dropped.
        if (g) begin
          state_d = StError;
          err_d   = 2'b01;
        end else if (ev_rise) begin
          ev_cnt_d = ev_inc;
          if (ev_inc == EvTarget) begin
            state_d = StWaitRd;
            timer_d = '0;
          end
        end
      end
      StWaitRd: begin
        if (!rd) begin
          state_d = StDone;
          done_d  = done_q + DONE_W'(1);
        end else if (timer_q == ToLast) begin
          state_d = StError;
          err_d   = 2'b10;
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
      end
      StDone: begin
        if (back) begin
          state_d  = StRun;
          ev_cnt_d = '0;
        end
      end
      StError: begin
        // Once retry reaches RetryMax this never fires: lockout until reset.
        if (back && !g && (retry_q < RetryMax)) begin
          state_d  = StRun;
          retry_d  = retry_q + RW'(1);
          ev_cnt_d = '0;
          err_d    = 2'b00;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      ev_q     <= 1'b0;
      ev_cnt_q <= '0;
      timer_q  <= '0;
      retry_q  <= '0;
      done_q   <= '0;
      err_q    <= 2'b00;
    end else begin
      state_q  <= state_d;
      ev_q     <= ev;
      ev_cnt_q <= ev_cnt_d;
      timer_q  <= timer_d;
      retry_q  <= retry_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign M        = (state_q == StRun) || (state_q == StWaitRd);
  assign LEV      = (state_q == StRun);
  assign Lerro    = (state_q == StError);
  assign D        = (state_q == StDone);
  assign state_o  = state_q;
  assign err_code = err_q;
  assign done_cnt = done_q;

endmodule

// File: tb/tb_mef_seq.sv
// Scoreboard bench for mef_seq: a reference model queues the expected post-edge state,
// outputs and counters for every driven cycle; directed scenarios then random traffic.
module tb_mef_seq;

  localparam int unsigned TbEvCount  = 4;
  localparam int unsigned TbTimeout  = 16;
  localparam int unsigned TbMaxRetry = 2;

  localparam int SIdle = 0, SRun = 1, SWait = 2, SDone = 3, SErr = 4;

  logic       clk = 1'b0;
  logic       reset, g, s, ev, rd, back;
  logic       M, LEV, Lerro, D;
  logic [2:0] state_o;
  logic [1:0] err_code;
  logic [7:0] done_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int st;
    int err;
    int dc;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  int m_st, m_evq, m_evcnt, m_timer, m_retry, m_done, m_err;

  mef_seq #(
    .EV_COUNT (TbEvCount),
    .EV_W     (4),
    .TIMEOUT  (TbTimeout),
    .TO_W     (8),
    .MAX_RETRY(TbMaxRetry),
    .DONE_W   (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .g       (g),
    .s       (s),
    .ev      (ev),
    .rd      (rd),
    .back    (back),
    .M       (M),
    .LEV     (LEV),
    .Lerro   (Lerro),
    .D       (D),
    .state_o (state_o),
    .err_code(err_code),
    .done_cnt(done_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_step();
    int rise;
    if (reset) begin
      m_st = SIdle; m_evq = 0; m_evcnt = 0; m_timer = 0; m_retry = 0; m_done = 0; m_err = 0;
      return;
    end
    rise = (ev && !m_evq) ? 1 : 0;
    case (m_st)
      SIdle: if (!g && !s) begin m_st = SRun; m_evcnt = 0; end
      SRun: begin
        if (g) begin
          m_st = SErr; m_err = 1;
        end else if (rise != 0) begin
          m_evcnt++;
          if (m_evcnt == TbEvCount) begin m_st = SWait; m_timer = 0; end
        end
      end
      SWait: begin
        if (!rd) begin
          m_st = SDone; m_done = (m_done + 1) % 256;
        end else if (m_timer == TbTimeout - 1) begin
          m_st = SErr; m_err = 2;
        end else begin
          m_timer++;
        end
      end
      SDone: if (back) begin m_st = SRun; m_evcnt = 0; end
      SErr: begin
        if (back && !g && m_retry < TbMaxRetry) begin
          m_st = SRun; m_retry++; m_evcnt = 0; m_err = 0;
        end
      end
      default: m_st = SIdle;
    endcase
    m_evq = ev ? 1 : 0;
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    e.st = m_st; e.err = m_err; e.dc = m_done;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("state", 32'(state_o), 32'(e.st));
    check("M", 32'(M), 32'((e.st == SRun) || (e.st == SWait)));
    check("LEV", 32'(LEV), 32'(e.st == SRun));
    check("Lerro", 32'(Lerro), 32'(e.st == SErr));
    check("D", 32'(D), 32'(e.st == SDone));
    check("err_code", 32'(err_code), 32'(e.err));
    check("done_cnt", 32'(done_cnt), 32'(e.dc));
  endtask

  // n separate rises; the last rise's edge is the one that leaves RUN
  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      ev = 1'b0; tick();
      ev = 1'b1; tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; g = 1'b0; s = 1'b1; ev = 1'b0; rd = 1'b1; back = 1'b0;
    tick(); tick();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_outs", 32'({M, LEV, Lerro, D}), 32'd0);
    check("rst_done", 32'(done_cnt), 32'd0);
    reset = 1'b0;

    // Nominal cycle
    s = 1'b0; tick();
    check("nom_run", 32'(state_o), 32'd1);
    pulses(4);
    check("nom_wait", 32'(state_o), 32'd2);
    rd = 1'b1; tick(); tick(); tick();
    rd = 1'b0; tick();
    check("nom_done", 32'(state_o), 32'd3);
    check("nom_done_cnt", 32'(done_cnt), 32'd1);

    // Level already high on RUN entry is not counted
    ev = 1'b1; tick();
    back = 1'b1; tick();
    back = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("lvl_still_run", 32'(state_o), 32'd1);
    pulses(4);
    check("lvl_wait", 32'(state_o), 32'd2);

    // Timeout: rd held high for TIMEOUT cycles
    rd = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("to_not_yet", 32'(state_o), 32'd2);
    tick();
    check("to_err", 32'(state_o), 32'd4);
    check("to_code", 32'(err_code), 32'd2);
    check("to_M", 32'(M), 32'd0);

    // Retry 1, then guard opens together with an ev rise
    back = 1'b1; tick(); back = 1'b0;
    check("retry1", 32'(state_o), 32'd1);
    check("retry1_code", 32'(err_code), 32'd0);
    ev = 1'b0; tick();
    g = 1'b1; ev = 1'b1; tick();
    check("guard_err", 32'(state_o), 32'd4);
    check("guard_code", 32'(err_code), 32'd1);

    // Retry 2, then rd drops on the timeout cycle
    g = 1'b0; back = 1'b1; tick(); back = 1'b0;
    check("retry2", 32'(state_o), 32'd1);
    pulses(4);
    rd = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    rd = 1'b0; tick();
    check("to_rd_wins", 32'(state_o), 32'd3);

    // Third error locks out
    back = 1'b1; tick(); back = 1'b0;
    g = 1'b1; tick(); g = 1'b0;
    back = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    back = 1'b0;
    check("lockout", 32'(state_o), 32'd4);

    // Reset clears lockout and retry
    reset = 1'b1; s = 1'b1; tick(); reset = 1'b0;
    check("unlock_idle", 32'(state_o), 32'd0);
    check("unlock_outs", 32'({M, LEV, Lerro, D}), 32'd0);
    s = 1'b0; tick();
    g = 1'b1; tick(); g = 1'b0;
    back = 1'b1; tick(); back = 1'b0;
    check("retry_cleared", 32'(state_o), 32'd1);

    // Reset mid WAIT_RD
    pulses(4);
    rd = 1'b1; tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_mid_wait", 32'(state_o), 32'd0);

    // done_cnt wraps after 256 cycles
    tick();
    for (int k = 0; k < 256; k++) begin
      pulses(4);
      rd = 1'b0; tick();
      if (k == 254) check("wrap_255", 32'(done_cnt), 32'd255);
      back = 1'b1; tick(); back = 1'b0;
    end
    check("wrap_0", 32'(done_cnt), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      g     = ($urandom_range(0, 7) == 0);
      s     = ($urandom_range(0, 5) == 0);
      ev    = 1'($urandom_range(0, 1));
      rd    = ($urandom_range(0, 9) != 0);
      back  = ($urandom_range(0, 3) == 0);
      tick();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
